// File: rtl/flit_input_buffer_pkg.sv
// Shared definitions for the router input-port flit buffer.
//  - flit_type_e   : type codes carried on out_type (DEFAULT/HEAD/PAYLOAD/TAIL)
//  - ID_*          : 3-bit identifier codes found in the top bits of an incoming flit
//  - frame_state_e : wormhole framing FSM states
//  - decode_type   : maps an identifier to a type code; DEFAULT marks an invalid flit
package flit_input_buffer_pkg;

    typedef enum logic [1:0] {
        TYPE_DEFAULT = 2'd0,
        TYPE_HEAD    = 2'd1,
        TYPE_PAYLOAD = 2'd2,
        TYPE_TAIL    = 2'd3
    } flit_type_e;

    localparam logic [2:0] ID_HEAD    = 3'd1;
    localparam logic [2:0] ID_PAYLOAD = 3'd2;
    localparam logic [2:0] ID_TAIL    = 3'd3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } frame_state_e;

    function automatic flit_type_e decode_type(input logic [2:0] id);
        flit_type_e t;
        case (id)
            ID_HEAD:    t = TYPE_HEAD;
            ID_PAYLOAD: t = TYPE_PAYLOAD;
            ID_TAIL:    t = TYPE_TAIL;
            default:    t = TYPE_DEFAULT;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Synchronous FIFO used as the flit store of the input buffer.
// Ports:
//  clk, rst        rising-edge clock, synchronous active-high reset (empties the FIFO)
//  push, wr_data   write request and data (ignored when full)
//  pop             read request (ignored when empty)
//  rd_data         head entry, all zeros when empty
//  full, empty     occupancy flags
module flit_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    import flit_input_buffer_pkg::*;

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == (PW+1)'(DEPTH));
    assign empty     = (count_r == {(PW+1){1'b0}});
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign rd_data   = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Storage array; left unreset because reads are masked while empty.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/flit_input_buffer.sv
// Router input-port stage: classifies incoming flits, enforces wormhole
// framing (HEAD ... PAYLOAD* ... TAIL) and buffers legal flits in flit_fifo.
// Malformed flits are consumed, dropped and flagged on frame_err.
// Ports:
//  clk, rst              clock, synchronous active-high reset
//  in_flit/in_valid/in_ready    link side handshake (in_ready = not full)
//  out_flit/out_type/out_valid/out_ready  head-of-FIFO to switch allocation
//  frame_err             one-cycle pulse after an accepted flit broke framing
// Optional feature macro FLIT_BUF_ERR_COUNT_EN adds err_count[15:0], a
// saturating count of frame_err pulses cleared by rst.
module flit_input_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int PhitPerFlit = 2,
    parameter int TYPE_WIDTH  = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH*PhitPerFlit-1:0] in_flit,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [DATA_WIDTH*PhitPerFlit-1:0] out_flit,
    output logic [TYPE_WIDTH-1:0]             out_type,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              frame_err
`ifdef FLIT_BUF_ERR_COUNT_EN
    ,
    output logic [15:0]                       err_count
`endif
);
    import flit_input_buffer_pkg::*;

    localparam int FW = DATA_WIDTH * PhitPerFlit;
    localparam int EW = FW + TYPE_WIDTH;

    frame_state_e    state_r;
    frame_state_e    state_next_s;
    flit_type_e      cls_s;
    logic            accept_s;
    logic            write_s;
    logic            err_s;
    logic            frame_err_r;
    logic            full_s;
    logic            empty_s;
    logic [EW-1:0]   rd_data_s;

    assign cls_s    = decode_type(in_flit[FW-1 -: 3]);
    // Gating on rst keeps the port closed during the reset cycle itself.
    assign in_ready = ~rst & ~full_s;
    assign accept_s = in_valid & in_ready;

    // Framing decisions: what to write, whether to flag, where to go next.
    always_comb begin
        state_next_s = state_r;
        write_s      = 1'b0;
        err_s        = 1'b0;
        if (accept_s) begin
            case (cls_s)
                TYPE_HEAD: begin
                    write_s      = 1'b1;
                    // A new HEAD inside a packet truncates the previous one.
                    err_s        = (state_r == ST_IN_PKT);
                    state_next_s = ST_IN_PKT;
                end
                TYPE_PAYLOAD: begin
                    if (state_r == ST_IN_PKT) begin
                        write_s = 1'b1;
                    end else begin
                        err_s   = 1'b1;
                    end
                end
                TYPE_TAIL: begin
                    if (state_r == ST_IN_PKT) begin
                        write_s      = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        err_s        = 1'b1;
                    end
                end
                default: begin
                    err_s = 1'b1;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Framing state and registered error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            frame_err_r <= err_s;
        end
    end

    assign frame_err = frame_err_r;

`ifdef FLIT_BUF_ERR_COUNT_EN
    logic [15:0] err_count_r;

    // Saturating error counter, stepped together with the frame_err pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_r <= 16'h0000;
        end else if (err_s && (err_count_r != 16'hFFFF)) begin
            err_count_r <= err_count_r + 16'h0001;
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign err_count = err_count_r;
`endif

    flit_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (write_s),
        .wr_data ({TYPE_WIDTH'(cls_s), in_flit}),
        .pop     (out_valid & out_ready),
        .rd_data (rd_data_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    // FIFO already returns zero when empty, so the head fields need no extra masking.
    assign out_valid = ~empty_s;
    assign out_flit  = rd_data_s[FW-1:0];
    assign out_type  = rd_data_s[EW-1:FW];

endmodule

// File: tb/tb_flit_input_buffer.sv
// Self-checking bench for flit_input_buffer (DATA_WIDTH=32, PhitPerFlit=2,
// FIFO_DEPTH=4). Directed scenarios use fixed expected values; the random
// scenario compares against a queue-based packet model.
module tb_flit_input_buffer;

    localparam int DEPTH = 4;
    localparam logic [63:0] H = 64'h2000_0000_0000_00AA;
    localparam logic [63:0] P = 64'h4000_0000_0000_00BB;
    localparam logic [63:0] T = 64'h6000_0000_0000_00CC;
    localparam logic [63:0] X = 64'hE000_0000_0000_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] in_flit = 64'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] out_flit;
    logic [1:0]  out_type;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        frame_err;
`ifdef FLIT_BUF_ERR_COUNT_EN
    logic [15:0] err_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: buffered {type, flit} entries, packet-open flag, expected pulse
    logic [65:0] mq[$];
    bit          m_in_pkt = 1'b0;
    bit          m_err = 1'b0;
    int          m_errcnt = 0;

    flit_input_buffer #(
        .DATA_WIDTH (32),
        .PhitPerFlit(2),
        .TYPE_WIDTH (2),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_flit  (in_flit),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_flit (out_flit),
        .out_type (out_type),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .frame_err(frame_err)
`ifdef FLIT_BUF_ERR_COUNT_EN
        ,
        .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Advance the model by one edge using the current inputs, then clock the DUT.
    task automatic tick();
        bit acc;
        bit pop;
        if (rst) begin
            mq.delete();
            m_in_pkt = 1'b0;
            m_err    = 1'b0;
            m_errcnt = 0;
        end else begin
            acc   = in_valid && (mq.size() < DEPTH);
            pop   = (mq.size() > 0) && out_ready;
            m_err = 1'b0;
            if (pop) void'(mq.pop_front());
            if (acc) begin
                case (in_flit[63:61])
                    3'd1: begin
                        if (m_in_pkt) m_err = 1'b1;
                        m_in_pkt = 1'b1;
                        mq.push_back({2'd1, in_flit});
                    end
                    3'd2: begin
                        if (m_in_pkt) mq.push_back({2'd2, in_flit});
                        else m_err = 1'b1;
                    end
                    3'd3: begin
                        if (m_in_pkt) begin
                            mq.push_back({2'd3, in_flit});
                            m_in_pkt = 1'b0;
                        end else m_err = 1'b1;
                    end
                    default: m_err = 1'b1;
                endcase
                if (m_err && m_errcnt < 65535) m_errcnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (out_flit !== 64'd0) begin errors++; $display("FAIL rst_out_flit got %h exp 0", out_flit); end
        checks++; if (out_type !== 2'd0) begin errors++; $display("FAIL rst_out_type got %0d exp 0", out_type); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err got %b exp 0", frame_err); end
        rst = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_basic_packet();
        logic [63:0] seq [3];
        seq[0] = H; seq[1] = P; seq[2] = T;
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_flit = seq[i]; in_valid = 1'b1;
            tick();
            checks++; if (out_valid !== 1'b1 || out_flit !== seq[i]) begin errors++; $display("FAIL basic_flit%0d got %h exp %h", i, out_flit, seq[i]); end
            checks++; if (out_type !== 2'(i + 1)) begin errors++; $display("FAIL basic_type%0d got %0d exp %0d", i, out_type, i + 1); end
            checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL basic_err%0d got %b exp 0", i, frame_err); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained got %b exp 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_f [5];
        bit acc;
        int got = 0;
        exp_f[0] = H;
        for (int i = 1; i < 5; i++) exp_f[i] = P | 64'(i);
        apply_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_flit = exp_f[i]; in_valid = 1'b1;
            tick();
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", in_ready); end
        in_flit = exp_f[4];
        tick();
        checks++; if (in_ready !== 1'b0 || out_flit !== H) begin errors++; $display("FAIL bp_hold got ready=%b head=%h exp 0/%h", in_ready, out_flit, H); end
        out_ready = 1'b1;
        for (int c = 0; c < 12 && got < 5; c++) begin
            if (out_valid) begin
                checks++; if (out_flit !== exp_f[got] || out_type !== (got == 0 ? 2'd1 : 2'd2)) begin
                    errors++; $display("FAIL bp_drain%0d got %h/%0d exp %h", got, out_flit, out_type, exp_f[got]);
                end
                got++;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) in_valid = 1'b0;
        end
        checks++; if (got != 5) begin errors++; $display("FAIL bp_count got %0d exp 5", got); end
    endtask

    task automatic test_orphan();
        apply_reset();
        out_ready = 1'b1;
        in_flit = P; in_valid = 1'b1;
        tick();
        checks++; if (frame_err !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL orphan_p got err=%b v=%b exp 1/0", frame_err, out_valid); end
        in_flit = T;
        tick();
        checks++; if (frame_err !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL orphan_t got err=%b v=%b exp 1/0", frame_err, out_valid); end
        in_valid = 1'b0;
        tick();
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL orphan_pulse got %b exp 0", frame_err); end
    endtask

    task automatic test_invalid();
        apply_reset();
        out_ready = 1'b1;
        in_flit = H; in_valid = 1'b1;
        tick();
        checks++; if (out_flit !== H || frame_err !== 1'b0) begin errors++; $display("FAIL inv_h got %h err=%b exp %h/0", out_flit, frame_err, H); end
        in_flit = X;
        tick();
        checks++; if (frame_err !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL inv_drop got err=%b v=%b exp 1/0", frame_err, out_valid); end
        in_flit = T;
        tick();
        checks++; if (out_flit !== T || out_type !== 2'd3 || frame_err !== 1'b0) begin errors++; $display("FAIL inv_t got %h/%0d err=%b exp %h/3/0", out_flit, out_type, frame_err, T); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_truncated();
        logic [63:0] seq [4];
        seq[0] = H; seq[1] = P; seq[2] = H | 64'h11; seq[3] = T;
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_flit = seq[i]; in_valid = 1'b1;
            tick();
            checks++; if (out_flit !== seq[i] || frame_err !== (i == 2)) begin errors++; $display("FAIL trunc%0d got %h err=%b exp %h", i, out_flit, frame_err, seq[i]); end
        end
        in_flit = P;
        tick();
        checks++; if (frame_err !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL trunc_idle got err=%b v=%b exp 1/0", frame_err, out_valid); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_midpacket();
        apply_reset();
        out_ready = 1'b0;
        in_flit = H; in_valid = 1'b1; tick();
        in_flit = P; tick(); tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_buffered got %b exp 1", out_valid); end
        rst = 1'b1; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b exp 0", in_ready); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_flit !== 64'd0) begin errors++; $display("FAIL mid_after_rst got v=%b r=%b f=%h exp 0/1/0", out_valid, in_ready, out_flit); end
        in_flit = P; in_valid = 1'b1;
        tick();
        checks++; if (frame_err !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_p_drop got err=%b v=%b exp 1/0", frame_err, out_valid); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int r;
        logic [2:0] id;
        logic [63:0] f;
        logic [63:0] ef;
        logic [1:0]  et;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            r = $urandom_range(0, 9);
            if (r < 2) id = 3'd1;
            else if (r < 5) id = 3'd2;
            else if (r < 7) id = 3'd3;
            else if (r == 7) id = 3'd0;
            else id = 3'($urandom_range(4, 7));
            f = {$urandom(), $urandom()};
            f[63:61] = id;
            in_flit   = f;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            tick();
            rst = 1'b0;
            #1;
            ef = (mq.size() > 0) ? mq[0][63:0] : 64'd0;
            et = (mq.size() > 0) ? mq[0][65:64] : 2'd0;
            checks++; if (out_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid c%0d got %b exp %b", c, out_valid, mq.size() > 0); end
            checks++; if (out_flit !== ef || out_type !== et) begin errors++; $display("FAIL rnd_head c%0d got %h/%0d exp %h/%0d", c, out_flit, out_type, ef, et); end
            checks++; if (in_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready c%0d got %b exp %b", c, in_ready, mq.size() < DEPTH); end
            checks++; if (frame_err !== m_err) begin errors++; $display("FAIL rnd_err c%0d got %b exp %b", c, frame_err, m_err); end
`ifdef FLIT_BUF_ERR_COUNT_EN
            checks++; if (err_count !== 16'(m_errcnt)) begin errors++; $display("FAIL rnd_errcnt c%0d got %0d exp %0d", c, err_count, m_errcnt); end
`endif
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_packet();
        test_backpressure();
        test_orphan();
        test_invalid();
        test_truncated();
        test_reset_midpacket();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
